dig_volt_avg: RTL and testbench

//  Parametrised ADC voltmeter front-end, successor to the fixed 8-bit dig_volt measurement path.

---
 rtl/dig_volt_avg_pkg.sv | 30 +++
 rtl/dig_volt_avg_seq_divider.sv | 73 +++++++
 rtl/dig_volt_avg.sv | 215 +++++++++++++++++++++
 tb/tb_dig_volt_avg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dig_volt_avg_pkg.sv
// Shared types and width helpers for the averaging voltmeter front-end.
package dig_volt_avg_pkg;

  typedef enum logic {
    ST_CAL = 1'b0,
    ST_RUN = 1'b1
  } meas_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int num_width(input int adc_w, input int volt_w);
    return adc_w + volt_w;
  endfunction

  function automatic int acc_width(input int adc_w, input int cal_log2, input int avg_log2);
    return adc_w + max_int(cal_log2, avg_log2);
  endfunction

endpackage

// File: rtl/dig_volt_avg_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved in
// the start cycle, so done pulses NUM_W-1 cycles after start.
module seq_divider
  import dig_volt_avg_pkg::*;
#(
  parameter int NUM_W = 21,
  parameter int DEN_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int CNT_W = clog2(NUM_W) + 1;

  logic [DEN_W-1:0] rem_q, rem_in, rem_nx;
  logic [DEN_W-1:0] den_q, den_in;
  logic [NUM_W-1:0] dq_q, dq_in, dq_nx;
  logic [DEN_W:0]   trial;
  logic             fits;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // dq holds the remaining dividend bits in its upper end and collects
  // quotient bits from the bottom.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    dq_in  = start ? num : dq_q;
    den_in = start ? den : den_q;
    trial  = {rem_in, dq_in[NUM_W-1]};
    fits   = (trial >= {1'b0, den_in});
    rem_nx = fits ? DEN_W'(trial - {1'b0, den_in}) : DEN_W'(trial);
    dq_nx  = {dq_in[NUM_W-2:0], fits};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rem_q  <= '0;
      dq_q   <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy_q <= 1'b0;
      end else if (start) begin
        rem_q  <= rem_nx;
        dq_q   <= dq_nx;
        den_q  <= den;
        cnt_q  <= CNT_W'(NUM_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_nx;
        dq_q  <= dq_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quot = dq_q;

endmodule

// File: rtl/dig_volt_avg.sv
// ADC voltmeter front-end: ad_clk generation, midpoint calibration, windowed
// averaging and signed millivolt conversion for the display driver.
//
// state | meaning
// CAL   | summing 2^CAL_LOG2 samples to find the zero midpoint
// RUN   | summing 2^AVG_LOG2-sample windows, conversion launched at each window end
module dig_volt_avg
  import dig_volt_avg_pkg::*;
#(
  parameter int ADC_W    = 8,
  parameter int AD_HALF  = 1,
  parameter int CAL_LOG2 = 10,
  parameter int AVG_LOG2 = 4,
  parameter int VOLT_MAX = 5000,
  parameter int VOLT_W   = 13
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADC_W-1:0]  ad_data,
  input  logic              cal_req,
  output logic              ad_clk,
  output logic [VOLT_W-1:0] volt,
  output logic              sign,
  output logic              volt_valid,
  output logic              cal_done
);

  localparam int NUM_W = num_width(ADC_W, VOLT_W);
  localparam int CNT_W = max_int(CAL_LOG2, AVG_LOG2);
  localparam int ACC_W = acc_width(ADC_W, CAL_LOG2, AVG_LOG2);
  localparam int HC_W  = max_int(clog2(AD_HALF), 1);

  localparam logic [HC_W-1:0]   HC_RELOAD  = HC_W'(AD_HALF - 1);
  localparam logic [CNT_W-1:0]  CAL_LAST   = CNT_W'((2 ** CAL_LOG2) - 1);
  localparam logic [CNT_W-1:0]  AVG_LAST   = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0]  ADC_FS     = '1;
  localparam logic [ADC_W-1:0]  MID_RST    = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [NUM_W-1:0]  VOLT_MAX_N = NUM_W'(VOLT_MAX);
  localparam logic [VOLT_W-1:0] VOLT_MAX_V = VOLT_W'(VOLT_MAX);

  // A conversion must finish before the next window can end.
  if ((2 ** AVG_LOG2) * 2 * AD_HALF <= NUM_W + 3) begin : g_bad_window
    $error("dig_volt_avg: averaging window shorter than conversion latency");
  end
  if (VOLT_MAX >= (2 ** VOLT_W)) begin : g_bad_volt_w
    $error("dig_volt_avg: VOLT_W too narrow for VOLT_MAX");
  end

  logic [HC_W-1:0]   hcnt_q;
  logic              sample_en;
  meas_state_t       state_q, state_d;
  logic              cal_end, win_end;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [CNT_W-1:0]  scnt_q;
  logic [ADC_W-1:0]  mid_q, avg_q;
  logic              conv_go_q;
  logic [ADC_W-1:0]  diff_c, den_c;
  logic              sgn_c;
  logic              prep_vld_q;
  logic [NUM_W-1:0]  num_q;
  logic [ADC_W-1:0]  den_q;
  logic              sgn_q, diff_nz_q;
  logic              div_start, fast_vld;
  logic              div_done;
  logic [NUM_W-1:0]  div_quot;
  logic [VOLT_W-1:0] volt_c;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt_q <= '0;
      ad_clk <= 1'b0;
    end else if (hcnt_q == '0) begin
      hcnt_q <= HC_RELOAD;
      ad_clk <= ~ad_clk;
    end else begin
      hcnt_q <= hcnt_q - 1'b1;
    end
  end

  assign sample_en = (hcnt_q == '0) && !ad_clk;
  assign acc_sum   = acc_q + ACC_W'(ad_data);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_CAL;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cal_end = 1'b0;
    win_end = 1'b0;
    if (cal_req) begin
      state_d = ST_CAL;
    end else if (sample_en) begin
      case (state_q)
        ST_CAL: if (scnt_q == CAL_LAST) begin
          cal_end = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: if (scnt_q == AVG_LAST) win_end = 1'b1;
        default: state_d = ST_CAL;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q     <= '0;
      scnt_q    <= '0;
      mid_q     <= MID_RST;
      avg_q     <= '0;
      cal_done  <= 1'b0;
      conv_go_q <= 1'b0;
    end else begin
      conv_go_q <= 1'b0;
      if (cal_req) begin
        acc_q    <= '0;
        scnt_q   <= '0;
        cal_done <= 1'b0;
      end else if (sample_en) begin
        if (cal_end || win_end) begin
          acc_q  <= '0;
          scnt_q <= '0;
        end else begin
          acc_q  <= acc_sum;
          scnt_q <= scnt_q + 1'b1;
        end
        if (cal_end) begin
          mid_q    <= ADC_W'(acc_sum >> CAL_LOG2);
          cal_done <= 1'b1;
        end
        if (win_end) begin
          avg_q     <= ADC_W'(acc_sum >> AVG_LOG2);
          conv_go_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    diff_c = '0;
    den_c  = '0;
    sgn_c  = 1'b0;
    if (avg_q >= mid_q) begin
      diff_c = avg_q - mid_q;
      den_c  = ADC_FS - mid_q;
    end else begin
      diff_c = mid_q - avg_q;
      den_c  = mid_q;
      sgn_c  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prep_vld_q <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      sgn_q      <= 1'b0;
      diff_nz_q  <= 1'b0;
    end else if (cal_req) begin
      prep_vld_q <= 1'b0;
    end else begin
      prep_vld_q <= conv_go_q;
      if (conv_go_q) begin
        num_q     <= NUM_W'(diff_c) * VOLT_MAX_N;
        den_q     <= den_c;
        sgn_q     <= sgn_c;
        diff_nz_q <= (diff_c != '0);
      end
    end
  end

  // A zero denominator (midpoint at full scale) bypasses the divider.
  assign div_start = prep_vld_q && (den_q != '0) && !cal_req;
  assign fast_vld  = prep_vld_q && (den_q == '0);

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (ADC_W)
  ) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (div_start),
    .abort     (cal_req),
    .num       (num_q),
    .den       (den_q),
    .done      (div_done),
    .quot      (div_quot)
  );

  assign volt_c = (div_quot > VOLT_MAX_N) ? VOLT_MAX_V : VOLT_W'(div_quot);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      volt       <= '0;
      sign       <= 1'b0;
      volt_valid <= 1'b0;
    end else begin
      volt_valid <= 1'b0;
      if (!cal_req) begin
        if (fast_vld) begin
          volt       <= diff_nz_q ? VOLT_MAX_V : '0;
          sign       <= diff_nz_q && sgn_q;
          volt_valid <= 1'b1;
        end else if (div_done) begin
          volt       <= volt_c;
          sign       <= sgn_q && (volt_c != '0);
          volt_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dig_volt_avg.sv
// Self-checking bench for dig_volt_avg: sample-level reference model checked
// every cycle, plus a table of steady-input cases and recalibration sequences.
module tb_dig_volt_avg;

  localparam int ADC_W    = 8;
  localparam int VOLT_W   = 13;
  localparam int AD_HALF  = 1;
  localparam int CAL_N    = 1024;
  localparam int AVG_N    = 16;
  localparam int VOLT_MAX = 5000;
  localparam int ADC_FS   = (1 << ADC_W) - 1;
  localparam int LAT_DIV  = ADC_W + VOLT_W + 2;
  localparam int LAT_FAST = 2;
  localparam int WIN_CYC  = AVG_N * 2 * AD_HALF;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              cal_req = 1'b0;
  logic [ADC_W-1:0]  ad_data = 8'd127;
  logic              ad_clk;
  logic [VOLT_W-1:0] volt;
  logic              sign;
  logic              volt_valid;
  logic              cal_done;

  dig_volt_avg dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ad_data    (ad_data),
    .cal_req    (cal_req),
    .ad_clk     (ad_clk),
    .volt       (volt),
    .sign       (sign),
    .volt_valid (volt_valid),
    .cal_done   (cal_done)
  );

  always #10 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int v; int s; } pend_t;
  pend_t pend[$];
  int m_k = 0, m_n = 0, m_sum = 0, m_mid = 127;
  bit m_in_cal = 1'b1;
  bit exp_valid = 1'b0, exp_sign = 1'b0, exp_cal_done = 1'b0, exp_adclk = 1'b0;
  int exp_volt = 0;

  function automatic void ref_convert(input int avg, input int mid,
                                      output int v, output int s, output bit fast);
    int diff, den;
    if (avg >= mid) begin diff = avg - mid; den = ADC_FS - mid; s = 0; end
    else            begin diff = mid - avg; den = mid;          s = 1; end
    fast = (den == 0);
    if (den == 0) v = (diff > 0) ? VOLT_MAX : 0;
    else          v = (diff * VOLT_MAX) / den;
    if (v > VOLT_MAX) v = VOLT_MAX;
    if (v == 0) s = 0;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    int v, s;
    bit fast;
    if (!sys_rst_n) begin
      m_k = 0; m_n = 0; m_sum = 0; m_mid = 127; m_in_cal = 1'b1;
      exp_valid = 0; exp_sign = 0; exp_volt = 0; exp_cal_done = 0; exp_adclk = 0;
      pend.delete();
    end else begin
      exp_valid = 1'b0;
      exp_adclk = ((m_k / AD_HALF) % 2) == 0;
      if (cal_req) begin
        m_n = 0; m_sum = 0; m_in_cal = 1'b1; exp_cal_done = 1'b0;
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due == m_k) begin
          exp_valid = 1'b1;
          exp_volt  = pend[0].v;
          exp_sign  = (pend[0].s != 0);
          pend.delete(0);
        end
        if (m_k % (2 * AD_HALF) == 0) begin
          m_sum += int'(ad_data);
          m_n++;
          if (m_in_cal && m_n == CAL_N) begin
            m_mid = m_sum / CAL_N;
            m_in_cal = 1'b0; exp_cal_done = 1'b1; m_n = 0; m_sum = 0;
          end else if (!m_in_cal && m_n == AVG_N) begin
            ref_convert(m_sum / AVG_N, m_mid, v, s, fast);
            pend.push_back('{due: m_k + (fast ? LAT_FAST : LAT_DIV), v: v, s: s});
            m_n = 0; m_sum = 0;
          end
        end
      end
      m_k++;
    end
  end

  // ---------------- per-cycle checker ----------------
  int dut_last_volt = -1;
  int dut_last_sign = -1;

  always @(negedge sys_clk) begin
    check("ctrl{ad_clk,cal_done,volt_valid}", {29'd0, ad_clk, cal_done, volt_valid},
          {29'd0, exp_adclk, exp_cal_done, exp_valid});
    check("volt", 32'(volt), 32'(exp_volt));
    check("sign", {31'd0, sign}, {31'd0, exp_sign});
    if (volt_valid) begin
      dut_last_volt = int'(volt);
      dut_last_sign = int'(sign);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int cycles, input int lo, input int hi, input bit rnd);
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      if (rnd) ad_data = 8'($urandom_range(0, ADC_FS));
      else     ad_data = (((i / (2 * AD_HALF)) % 2) == 1) ? 8'(hi) : 8'(lo);
    end
  endtask

  task automatic wait_cal(input int val, input bit rnd);
    int i;
    i = 0;
    while (cal_done !== 1'b1 && i < CAL_N * 2 * AD_HALF + 100) begin
      drive(1, val, val, rnd);
      i++;
    end
    check("cal_done_timeout", {31'd0, cal_done}, 32'd1);
  endtask

  task automatic pulse_cal();
    @(negedge sys_clk);
    cal_req = 1'b1;
    @(negedge sys_clk);
    cal_req = 1'b0;
  endtask

  task automatic check_last(input string name, input int v, input int s);
    #2;
    check({name, " volt"}, 32'(dut_last_volt), 32'(v));
    check({name, " sign"}, 32'(dut_last_sign), 32'(s));
  endtask

  typedef struct { int lo; int hi; int volt; int sgn; } vec_t;
  vec_t tbl[10];

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // expected results with mid = 127 (den+ = 128, den- = 127)
    tbl[0] = '{127, 127,    0, 0};
    tbl[1] = '{255, 255, 5000, 0};
    tbl[2] = '{  0,   0, 5000, 1};
    tbl[3] = '{191, 191, 2500, 0};
    tbl[4] = '{ 63,  63, 2519, 1};
    tbl[5] = '{190, 192, 2500, 0};
    tbl[6] = '{150, 150,  898, 0};
    tbl[7] = '{120, 120,  275, 1};
    tbl[8] = '{128, 126,    0, 0};
    tbl[9] = '{126, 126,   39, 1};

    repeat (3) @(negedge sys_clk);
    #1;
    check("rst volt", 32'(volt), 32'd0);
    check("rst sign", {31'd0, sign}, 32'd0);
    check("rst volt_valid", {31'd0, volt_valid}, 32'd0);
    check("rst cal_done", {31'd0, cal_done}, 32'd0);
    check("rst ad_clk", {31'd0, ad_clk}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    wait_cal(127, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(4 * WIN_CYC, tbl[i].lo, tbl[i].hi, 1'b0);
      check_last($sformatf("tbl%0d", i), tbl[i].volt, tbl[i].sgn);
    end

    drive(12 * WIN_CYC, 0, 0, 1'b1);

    // recalibration requested while a division is in flight
    for (int i = 0; i < WIN_CYC + 2 && pend.size() == 0; i++) drive(1, 100, 100, 1'b0);
    drive(6, 100, 100, 1'b0);
    pulse_cal();
    drive(40, 100, 100, 1'b0);
    #2 check("cal_req cal_done", {31'd0, cal_done}, 32'd0);
    wait_cal(100, 1'b0);
    drive(4 * WIN_CYC, 100, 100, 1'b0);
    check_last("recal100", 0, 0);

    // full-scale midpoint, with a calibration restart part-way through
    pulse_cal();
    drive(500, 255, 255, 1'b0);
    pulse_cal();
    wait_cal(255, 1'b0);
    drive(4 * WIN_CYC, 255, 255, 1'b0);
    check_last("mid255 fs", 0, 0);
    drive(4 * WIN_CYC, 200, 200, 1'b0);
    check_last("mid255 d200", 1078, 1);

    // asynchronous reset in the middle of a window
    drive(7, 200, 200, 1'b0);
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst volt", 32'(volt), 32'd0);
    check("arst sign", {31'd0, sign}, 32'd0);
    check("arst volt_valid", {31'd0, volt_valid}, 32'd0);
    check("arst cal_done", {31'd0, cal_done}, 32'd0);
    check("arst ad_clk", {31'd0, ad_clk}, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    wait_cal(0, 1'b1);
    drive(10 * WIN_CYC, 0, 0, 1'b1);

    @(negedge sys_clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
